// File: rtl/event_or_capture_pkg.sv
// ============================================================================
// Module  : event_or_capture_pkg
// Brief   : Edge-mode encodings, FSM states and the per-channel match helper.
// Config  : EVENT_OR_SYNC_EN selects how many clocks the arm delay spans.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package event_or_capture_pkg;

  localparam logic [1:0] EV_OFF = 2'b00;
  localparam logic [1:0] EV_POS = 2'b01;
  localparam logic [1:0] EV_NEG = 2'b10;
  localparam logic [1:0] EV_ANY = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Clocks after reset before the edge detectors hold trustworthy history.
`ifdef EVENT_OR_SYNC_EN
  localparam int c_ARM_CYC = 3;
`else
  localparam int c_ARM_CYC = 1;
`endif

  function automatic logic edge_match(input logic [1:0] mode, input logic p, input logic s);
    logic m;
    m = 1'b0;
    case (mode)
      EV_OFF: m = 1'b0;
      EV_POS: m = ~p & s;
      EV_NEG: m = p & ~s;
      EV_ANY: m = p ^ s;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/event_or_capture_ev_edge_det.sv
// ============================================================================
// Module  : event_or_capture_ev_edge_det
// Brief   : One event channel: optional 2-flop sync, previous-sample flop and
//           mode match. Config macro: EVENT_OR_SYNC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module event_or_capture_ev_edge_det
  import event_or_capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ev,
  input  logic [1:0] i_mode,
  input  logic       i_armed,
  input  logic       i_enable,
  output logic       o_hit
);

  logic w_samp;
  logic r_prev;

`ifdef EVENT_OR_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_ev;
      r_sync2 <= r_sync1;
    end
  end

  assign w_samp = r_sync2;
`else
  assign w_samp = i_ev;
`endif

  // History tracks the input even while the channel is off or disabled, so
  // turning it on later cannot fabricate an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_samp;
  end

  assign o_hit = i_armed & i_enable & edge_match(i_mode, r_prev, w_samp);

endmodule

`default_nettype wire

// File: rtl/event_or_capture.sv
// ============================================================================
// Module  : event_or_capture
// Brief   : N-channel edge-event OR trigger capturing a data word into a
//           valid/ready register with a saturating drop counter.
//           Config macro: EVENT_OR_SYNC_EN (input synchronizers).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module event_or_capture
  import event_or_capture_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ev_in,
  input  logic [2*NUM_CH-1:0] ch_mode,
  input  logic                enable,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   cap_data,
  output logic [NUM_CH-1:0]   cap_src,
  output logic                cap_valid,
  input  logic                cap_ready,
  output logic                ev_pulse,
  output logic [CNT_W-1:0]    drop_cnt
);

  logic [1:0]        r_arm_cnt;
  logic              r_armed;
  logic [NUM_CH-1:0] w_hit;
  logic              w_ev;
  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_drop;
  logic [DATA_W-1:0] r_cap_data;
  logic [NUM_CH-1:0] r_cap_src;
  logic              r_ev_pulse;
  logic [CNT_W-1:0]  r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= 2'd0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == 2'(c_ARM_CYC - 1)) r_armed   <= 1'b1;
      else                                r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    event_or_capture_ev_edge_det u_det (
      .clk      (clk),
      .rst      (rst),
      .i_ev     (ev_in[i]),
      .i_mode   (ch_mode[2*i +: 2]),
      .i_armed  (r_armed),
      .i_enable (enable),
      .o_hit    (w_hit[i])
    );
  end

  assign w_ev = |w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Accepting and recapturing in one cycle keeps back-to-back events bubble-free.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ev) begin
          w_load = 1'b1;
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cap_ready) begin
          if (w_ev) w_load = 1'b1;
          else      w_next = ST_IDLE;
        end else if (w_ev) begin
          w_drop = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_data <= '0;
      r_cap_src  <= '0;
      r_ev_pulse <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ev_pulse <= w_ev;
      if (w_load) begin
        r_cap_data <= data_in;
        r_cap_src  <= w_hit;
      end
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign cap_data  = r_cap_data;
  assign cap_src   = r_cap_src;
  assign cap_valid = (r_state == ST_HOLD);
  assign ev_pulse  = r_ev_pulse;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_event_or_capture.sv
// ============================================================================
// Module  : tb_event_or_capture
// Brief   : Self-checking bench for event_or_capture (honours EVENT_OR_SYNC_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_event_or_capture;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
`ifdef EVENT_OR_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 3;
  localparam int ARM  = 3;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 1;
  localparam int ARM  = 1;
`endif
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_CH-1:0]   ev_in = '0;
  logic [2*NUM_CH-1:0] ch_mode = '0;
  logic                enable = 1'b0;
  logic [DATA_W-1:0]   data_in = '0;
  logic [DATA_W-1:0]   cap_data;
  logic [NUM_CH-1:0]   cap_src;
  logic                cap_valid;
  logic                cap_ready = 1'b0;
  logic                ev_pulse;
  logic [CNT_W-1:0]    drop_cnt;

  event_or_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_in     (ev_in),
    .ch_mode   (ch_mode),
    .enable    (enable),
    .data_in   (data_in),
    .cap_data  (cap_data),
    .cap_src   (cap_src),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .ev_pulse  (ev_pulse),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: sample history, arming delay and the capture slot.
  logic [NUM_CH-1:0] m_prev, m_h1, m_h2, m_src;
  logic [DATA_W-1:0] m_data;
  bit                m_valid, m_pulse;
  int                m_cyc, m_drop;

  function automatic void model_reset();
    m_prev = '0; m_h1 = '0; m_h2 = '0; m_src = '0; m_data = '0;
    m_valid = 1'b0; m_pulse = 1'b0; m_cyc = 0; m_drop = 0;
  endfunction

  function automatic void model_step();
    logic [NUM_CH-1:0] s, hit;
    logic [1:0]        md;
    s = SYNC ? m_h2 : ev_in;
    m_h2 = m_h1;
    m_h1 = ev_in;
    hit = '0;
    if (m_cyc >= ARM && enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        md = ch_mode[2*i +: 2];
        case (md)
          2'b01:   hit[i] = !m_prev[i] && s[i];
          2'b10:   hit[i] = m_prev[i] && !s[i];
          2'b11:   hit[i] = m_prev[i] != s[i];
          default: hit[i] = 1'b0;
        endcase
      end
    end
    m_prev = s;
    if (m_cyc < ARM) m_cyc++;
    m_pulse = (hit != 0);
    if (!m_valid) begin
      if (hit != 0) begin m_valid = 1'b1; m_data = data_in; m_src = hit; end
    end else if (cap_ready) begin
      if (hit != 0) begin m_data = data_in; m_src = hit; end
      else m_valid = 1'b0;
    end else if (hit != 0 && m_drop < DROP_MAX) begin
      m_drop++;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk); #1;
      if (rst) model_reset();
      else     model_step();
      check("per-cycle outputs",
            {11'd0, cap_valid, ev_pulse, cap_src, cap_data, drop_cnt},
            {11'd0, m_valid, m_pulse, m_src, m_data, m_drop[CNT_W-1:0]});
    end
  end

  task automatic do_reset(input logic [NUM_CH-1:0] ev, input logic [2*NUM_CH-1:0] mode);
    @(negedge clk);
    rst = 1'b1; ev_in = ev; ch_mode = mode; enable = 1'b1; cap_ready = 1'b0; data_in = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bit          bad;
    int          lat, first_v, last_v, idx;
    logic [7:0]  got[$];

    // 1: single posedge capture
    do_reset(3'b000, {2'b11, 2'b01, 2'b01});
    ev_in = 3'b001; data_in = 8'hA5;
    repeat (LAT) @(posedge clk); #1;
    check("t1 valid", cap_valid, 1);
    check("t1 data", cap_data, 8'hA5);
    check("t1 src", cap_src, 3'b001);
    check("t1 pulse", ev_pulse, 1);
    @(negedge clk); cap_ready = 1'b1;
    @(posedge clk); #1;
    check("t1 release valid", cap_valid, 0);
    check("t1 pulse one cycle", ev_pulse, 0);

    // 2: levels high through reset release are not edges
    @(negedge clk);
    rst = 1'b1; ev_in = 3'b111; ch_mode = 6'b111111; enable = 1'b1; cap_ready = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (cap_valid || ev_pulse) bad = 1'b1; end
    check("t2 quiet after reset", bad, 0);

    // 3: simultaneous hits on channels 0 and 2
    do_reset(3'b001, {2'b11, 2'b00, 2'b10});
    cap_ready = 1'b1; ev_in = 3'b110; data_in = 8'h3C;
    repeat (LAT) @(posedge clk); #1;
    check("t3 valid", cap_valid, 1);
    check("t3 src", cap_src, 3'b101);
    check("t3 data", cap_data, 8'h3C);

    // 4: backpressure, drop counter saturates
    do_reset(3'b000, {4'b0000, 2'b11});
    ev_in = 3'b001; data_in = 8'h11;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      ev_in[0] = ~ev_in[0];
      data_in = (j < LAT) ? 8'h11 : 8'hEE;
    end
    repeat (LAT + 1) @(posedge clk); #1;
    check("t4 data held", cap_data, 8'h11);
    check("t4 drop saturated", drop_cnt, 8'hFF);
    check("t4 still valid", cap_valid, 1);

    // 5: back-to-back events with ready high
    do_reset(3'b000, {4'b0000, 2'b11});
    cap_ready = 1'b1; first_v = -1; last_v = -1;
    for (int j = 0; j <= LAT + 3; j++) begin
      if (j < 3) ev_in[0] = ~ev_in[0];
      idx = j - (LAT - 1);
      data_in = (idx >= 0 && idx < 3) ? 8'(idx + 1) : 8'h00;
      @(posedge clk); #1;
      if (cap_valid) begin
        got.push_back(cap_data);
        if (first_v < 0) first_v = j;
        last_v = j;
      end
      @(negedge clk);
    end
    check("t5 accept count", got.size(), 3);
    if (got.size() == 3) begin
      check("t5 word0", got[0], 8'h01);
      check("t5 word1", got[1], 8'h02);
      check("t5 word2", got[2], 8'h03);
    end
    check("t5 contiguous", last_v - first_v, 2);
    check("t5 drop", drop_cnt, 0);

    // 6: latency, then reset mid-HOLD
    do_reset(3'b000, {4'b0000, 2'b01});
    ev_in = 3'b001; data_in = 8'h5A; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (cap_valid) begin lat = k; break; end
    end
    check("t6 latency", lat, LAT);
    @(negedge clk); rst = 1'b1; #1;
    check("t6 async reset valid", cap_valid, 0);
    check("t6 async reset data", cap_data, 0);
    @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (cap_valid || ev_pulse) bad = 1'b1; end
    check("t6 quiet after reset", bad, 0);

    // Randomized traffic against the model
    do_reset(3'b000, 6'($urandom));
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(499, 0) == 0) rst = 1'b1;
      ev_in     = 3'($urandom);
      data_in   = 8'($urandom);
      enable    = ($urandom_range(7, 0) != 0);
      cap_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) ch_mode = 6'($urandom);
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
